pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush/halt sequencer for the 5-stage pipeline. Detects load-use and branch-operand hazards that the EX forwarding path cannot resolve. Generates PC / IF-ID write enables and bubble/flush controls. Runs the debug halt → drain → single-step → resume state machine. Sits beside the ID stage, driven by ID/EX/MEM pipeline fields and the debug unit.

## Interface
- DRAIN_CYCLES, 3, cycles after a halt request before the pipeline reports halted (EX, MEM, WB empty)
- CNT_W, 16, width of the saturating stall-cycle counter
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_id_rs1, i_id_rs2  in  5 each  source registers of the instruction in ID
- i_id_uses_rs2  in  1  ID instruction reads rs2
- i_id_branch  in  1  ID holds a branch/JALR whose operands are compared/used in ID
- i_id_taken  in  1  branch/jump in ID resolved taken this cycle
- i_id_halt  in  1  ID holds the HALT instruction
- i_ex_rd  in  5  EX destination; i_ex_RegWrite, i_ex_MemRead  in  1 each  EX controls
- i_mem_rd  in  5  MEM destination; i_mem_MemRead  in  1  MEM control
- i_dbg_halt_req, i_dbg_step, i_dbg_resume, i_dbg_clr  in  1 each  single-cycle debug pulses
- o_pc_write  out  1  PC load enable
- o_if_id_write  out  1  IF/ID register enable
- o_if_id_flush  out  1  IF/ID replaced by NOP
- o_id_ex_bubble  out  1  ID/EX loaded with NOP controls
- o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB and register-file write
- o_halted  out  1  pipeline frozen and empty
- o_end  out  1  halted by HALT instruction (sticky)
- o_step_done  out  1  one-cycle pulse after a completed step
- o_stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Hazard terms are combinational, evaluated every cycle. x0 never matches.
  - ld_use: i_ex_MemRead & ex_rd≠0 & (ex_rd==rs1 | (uses_rs2 & ex_rd==rs2)).
  - br_ex: i_id_branch & i_ex_RegWrite & ex_rd≠0 & ex_rd matches rs1/rs2.
  - br_mem: i_id_branch & i_mem_MemRead & mem_rd≠0 & match.
  - stall = ld_use | br_ex | br_mem.
- States: RUN, DRAIN, HALTED, STEP.
- RUN:
  - stall → pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, pipe_en=1.
  - Otherwise everything enabled; if_id_flush = i_id_taken.
  - A taken branch that is stalled is not flushed until its stall clears.
- RUN → DRAIN:
  - On i_id_halt (and not stall), or on i_dbg_halt_req.
  - The counter loads DRAIN_CYCLES-1.
  - A HALT instruction also sets the o_end flag.
- DRAIN:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_en=1.
  - The counter decrements each cycle; at 0 → HALTED.
- HALTED: o_halted=1, pipe_en=0, pc_write=0, if_id_write=0, bubble=0, flush=0.
  - i_dbg_resume & !o_end → RUN.
  - Else i_dbg_step & !o_end → STEP.
  - Resume/step are ignored while o_end=1; only reset clears o_end.
- STEP:
  - Exactly one cycle with RUN outputs: hazard logic applies; pipe_en=1.
  - Next state is HALTED, with o_step_done=1 in that first HALTED cycle.
  - If ID holds HALT during STEP, o_end sets.
- Simultaneous debug pulses in HALTED: resume beats step.
- i_dbg_halt_req in DRAIN/HALTED/STEP is ignored.
- Stall counter: increments in RUN/STEP on each cycle with stall=1 and saturates at all-ones. i_dbg_clr zeroes it and takes priority over the increment.
- Reset (any time, including mid-DRAIN):
  - State RUN, counters 0, o_end=0.
  - Outputs: pc_write=1, if_id_write=1, pipe_en=1, flush/bubble/halted/step_done=0, stall_cnt=0.

## Timing
- Enables, bubble and flush are combinational from current inputs plus state. Zero-cycle latency: they act at the same edge.
- Load-use costs 1 stall cycle. Branch after ALU op costs 1. Branch after load costs 2 (br_ex, then br_mem).
- Halt: o_halted rises exactly DRAIN_CYCLES cycles after the cycle that accepted the request.
- Step: 1 pipeline cycle; o_step_done pulses 1 cycle after the step pulse's accepting edge.

## Test plan
- Load-use: EX lw x5, ID add x6,x5,x1 → 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cnt=1. Same with rd=x0 → no stall.
- Branch after load: EX lw x7, ID beq x7,x2 taken → 2 stall cycles, then if_id_flush=1 for one cycle; stall_cnt=2.
- HALT in ID, DRAIN_CYCLES=3 → o_halted=1 3 cycles later with o_end=1. i_dbg_resume and i_dbg_step then have no effect.
- Debug halt_req in RUN → halted after 3 cycles. Step → one cycle with pipe_en=1, then o_step_done=1. Resume and step in the same cycle → RUN.
- Assert i_rst_n low mid-DRAIN → outputs return to reset values immediately, without a clock edge. The first cycle after release is in RUN.
- CNT_W=2: 5 consecutive stalls → stall_cnt saturates at 3. i_dbg_clr together with a stall → 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer beside ID: hazard enables are combinational (zero latency);
// debug FSM halts DRAIN_CYCLES cycles after acceptance; stalls hold PC and IF/ID and bubble ID/EX.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs2,
  input  logic             i_id_branch,
  input  logic             i_id_taken,
  input  logic             i_id_halt,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_RegWrite,
  input  logic             i_ex_MemRead,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_MemRead,
  input  logic             i_dbg_halt_req,
  input  logic             i_dbg_step,
  input  logic             i_dbg_resume,
  input  logic             i_dbg_clr,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_pipe_en,
  output logic             o_halted,
  output logic             o_end,
  output logic             o_step_done,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    drain_cnt;
  logic             end_q;
  logic             step_done_q;
  logic [CNT_W-1:0] stall_cnt;

  logic ex_hit, mem_hit, ld_use, br_ex, br_mem, stall, running;

  // x0 is hardwired zero, so it never creates a dependency
  assign ex_hit  = (i_ex_rd != 5'd0) &&
                   ((i_ex_rd == i_id_rs1) || (i_id_uses_rs2 && (i_ex_rd == i_id_rs2)));
  assign mem_hit = (i_mem_rd != 5'd0) &&
                   ((i_mem_rd == i_id_rs1) || (i_id_uses_rs2 && (i_mem_rd == i_id_rs2)));
  assign ld_use  = i_ex_MemRead && ex_hit;
  assign br_ex   = i_id_branch && i_ex_RegWrite && ex_hit;
  assign br_mem  = i_id_branch && i_mem_MemRead && mem_hit;
  assign stall   = ld_use || br_ex || br_mem;
  assign running = (state == RUN) || (state == STEP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:    if (i_dbg_halt_req || (i_id_halt && !stall)) state_nxt = DRAIN;
      DRAIN:  if (drain_cnt <= DW'(1)) state_nxt = HALTED;
      HALTED: if (!end_q) begin
                if (i_dbg_resume)    state_nxt = RUN;
                else if (i_dbg_step) state_nxt = STEP;
              end
      STEP:   state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_en      = 1'b1;
    o_halted       = 1'b0;
    case (state)
      RUN, STEP: begin
        // a stalled taken branch waits to flush until its operands are ready
        o_pc_write     = !stall;
        o_if_id_write  = !stall;
        o_id_ex_bubble = stall;
        o_if_id_flush  = !stall && i_id_taken;
      end
      DRAIN: begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_id_ex_bubble = 1'b1;
      end
      HALTED: begin
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_pipe_en     = 1'b0;
        o_halted      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drain_cnt   <= '0;
      end_q       <= 1'b0;
      step_done_q <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (state == RUN && state_nxt == DRAIN)
        drain_cnt <= DW'(DRAIN_CYCLES - 1);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DW'(1);

      if ((state == RUN && i_id_halt && !stall) || (state == STEP && i_id_halt))
        end_q <= 1'b1;

      step_done_q <= (state == STEP);

      if (i_dbg_clr)
        stall_cnt <= '0;
      else if (running && stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign o_end       = end_q;
  assign o_step_done = step_done_q;
  assign o_stall_cnt = stall_cnt;

endmodule
